// File: rtl/su_mac_acc.sv
// rtl/su_mac_acc.sv - signed multiply-accumulate collector with valid/ready result handoff (optional SU_MAC_SAT_EN)
module su_mac_acc #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] beats,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] res_acc_q;
  logic [CNT_W-1:0] res_cnt_q;
  logic             res_ovf_q;

  logic             accept;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_w;
  logic             add_ovf;
  logic [ACC_W-1:0] add_res;
  logic             cnt_full;
  logic             load_result;

  assign accept   = in_valid & in_ready_q;
  assign prod_ext = {{(ACC_W-8){prod[7]}}, prod};
  // One extra bit keeps the true sign of the sum so overflow is a simple sign disagreement.
  assign sum_w    = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign add_ovf  = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign cnt_full = (cnt_q == CNT_MAX);

`ifdef SU_MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // Clamp toward the side the true (wide) sum fell on.
  always_comb begin
    add_res = sum_w[ACC_W-1:0];
    if (add_ovf) add_res = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
  end
`else
  assign add_res = sum_w[ACC_W-1:0];
`endif

  // Next-state and datapath update for IDLE/ACCUM/HOLD.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = add_res;
          cnt_d = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
          ovf_d = ovf_q | add_ovf | cnt_full;
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers capture only on entry to HOLD so they hold the last result otherwise.
  assign load_result = (state_d == HOLD) && (state_q != HOLD);

  // State, accumulator and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_acc_q   <= '0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d != HOLD);
      out_valid_q <= (state_d == HOLD);
      if (load_result) begin
        res_acc_q <= acc_d;
        res_cnt_q <= cnt_d;
        res_ovf_q <= ovf_d;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = res_acc_q;
  assign beats     = res_cnt_q;
  assign ovf       = res_ovf_q;

endmodule

// File: doc/su_mac_acc.md
SU_MAC_ACC -- requirements
Module: su_mac_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 16, accumulator/result width in bits (legal 9..32).
REQ-002 SHALL have parameter CNT_W, default 8, beat-counter width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  prod/in_last carry a beat.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port prod  input  8  two's-complement product from the 4x4 signed x unsigned multiplier (range -120..105).
REQ-008 SHALL have port in_last  input  1  marks the final beat of a dot-product.
REQ-009 SHALL have port out_valid  output  1  acc_out/beats/ovf hold a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port acc_out  output  ACC_W  signed accumulated result.
REQ-012 SHALL have port beats  output  CNT_W  number of beats in the result.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag for the result.

Function
REQ-014 SHALL implement states IDLE, ACCUM, HOLD.
REQ-015 SHALL accept a beat only when in_valid and in_ready are both 1.
REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
REQ-017 SHALL, on a beat accepted in IDLE, load acc = sign-extended prod, cnt = 1, ovf = 0, and go to ACCUM (or HOLD if in_last).
REQ-018 SHALL, on a beat accepted in ACCUM, set acc = acc + sign-extended prod, cnt = cnt + 1, and go to HOLD if in_last.
REQ-019 SHALL present acc_out, beats, ovf with out_valid = 1 on the cycle after the in_last beat is accepted (latency 1).
REQ-020 SHALL hold acc_out, beats and ovf stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL, in HOLD with out_ready = 1, deassert out_valid next cycle and return to IDLE; no beat is accepted in that same cycle.
REQ-022 SHALL keep acc_out, beats and ovf at their last values when out_valid = 0; consumers ignore them.
REQ-023 SHALL set ovf when the signed ACC_W addition overflows; ovf stays set until the next IDLE load.
REQ-024 SHALL saturate cnt at 2^CNT_W-1 (no wrap) and set ovf when a beat arrives at the saturated count.
REQ-025 SHALL make in_valid = 0 a stall in ACCUM: state, acc and cnt are unchanged.
REQ-026 SHALL ignore prod and in_last whenever in_valid = 0.

Reset
REQ-027 SHALL, while rst_n = 0, force state IDLE, acc = 0, cnt = 0, ovf = 0, out_valid = 0, and in_ready = 0.
REQ-028 SHALL drive in_ready = 1 from the first clock edge after rst_n deasserts.
REQ-029 SHALL discard a partial accumulation or a pending HOLD result if rst_n asserts mid-operation; no out_valid follows.

Configuration
REQ-030 SHALL, with macro SU_MAC_SAT_EN defined, clamp an overflowing addition to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and still set ovf.
REQ-031 SHALL, without SU_MAC_SAT_EN, wrap an overflowing addition modulo 2^ACC_W and set ovf.

Verification
REQ-032 SHALL cover: beats 105, -120, 7 (last on 3rd), out_ready = 1 -> one cycle later acc_out = -8, beats = 3, ovf = 0, out_valid for 1 cycle.
REQ-033 SHALL cover: single beat prod = -1 with in_last -> acc_out = 0xFFFF, beats = 1; out_ready held 0 for 5 cycles -> outputs stable, in_ready = 0 throughout.
REQ-034 SHALL cover: ACC_W = 9, beats 105, 105, 105 (last on 3rd) -> with SU_MAC_SAT_EN acc_out = 255; without it acc_out = 315 mod 512 = -197; ovf = 1 in both builds.
REQ-035 SHALL cover: CNT_W = 2, five beats of +1 -> beats = 3, ovf = 1, acc_out = 5.
REQ-036 SHALL cover: rst_n pulsed low after 2 of 4 beats -> no out_valid; a new 2-beat stream 10, 20 then gives acc_out = 30, beats = 2.
REQ-037 SHALL cover: in_valid toggling 1/0 every cycle during a 4-beat stream of +3 -> acc_out = 12, beats = 4.
